// File: rtl/ctrl_pkg.sv
// Shared opcodes, control enums and the execute control bundle for the decode stage.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_OP_32  = 7'b0111011;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluXor   = 4'd4,
        AluSlt   = 4'd5,
        AluSltu  = 4'd6,
        AluSll   = 4'd7,
        AluSrl   = 4'd8,
        AluSra   = 4'd9,
        AluPassB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ResAlu    = 2'b00,
        ResMem    = 2'b01,
        ResPc4    = 2'b10,
        ResMulDiv = 2'b11
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        alu_ctrl_e   alu_ctrl;
        logic        alu_src;
        logic        src_a_pc;
        logic        jump_reg;
        logic        is_word_op;
        logic        is_muldiv;
        logic        illegal;
    } ctrl_bundle_t;

    // alt is funct7[5]; sub_ok is clear for immediates, where funct3=000 is always ADD.
    function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3, input logic alt,
                                                  input logic sub_ok);
        alu_ctrl_e op;
        case (funct3)
            3'b000:  op = (alt && sub_ok) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational decode of one instruction word into the execute control bundle.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic [31:0]  i_instr,
    output ctrl_bundle_t o_ctrl,
    output logic         o_dec_muldiv
);

    localparam bit WordOk = (XLEN == 32'd64);

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic         w_is_word;
    logic         w_illegal;
    ctrl_bundle_t w_ctrl;
    logic         w_unused_fields;

    assign w_opcode        = i_instr[6:0];
    assign w_funct3        = i_instr[14:12];
    assign w_funct7        = i_instr[31:25];
    assign w_is_word       = (w_opcode == OP_OP_32) || (w_opcode == OP_IMM_32);
    assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7]};

    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        case (w_opcode)
            OP_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.result_src = ResMem;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_ctrl   = AluAdd;
            end
            OP_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_ctrl  = AluAdd;
            end
            OP_OP, OP_OP_32: begin
                if (w_is_word && !WordOk) begin
                    w_illegal = 1'b1;
                end else if (w_funct7 == F7_MULDIV) begin
                    if (!ENABLE_M) begin
                        w_illegal = 1'b1;
                    end else begin
                        w_ctrl.reg_write  = 1'b1;
                        w_ctrl.result_src = ResMulDiv;
                        w_ctrl.is_muldiv  = 1'b1;
                    end
                end else begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_ctrl  = alu_from_funct3(w_funct3, w_funct7[5], 1'b1);
                end
                w_ctrl.is_word_op = w_is_word;
            end
            OP_IMM, OP_IMM_32: begin
                if (w_is_word && !WordOk) begin
                    w_illegal = 1'b1;
                end else begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_src   = 1'b1;
                    w_ctrl.alu_ctrl  = alu_from_funct3(w_funct3, w_funct7[5], 1'b0);
                end
                w_ctrl.is_word_op = w_is_word;
            end
            OP_BRANCH: begin
                w_ctrl.branch = 1'b1;
                case (w_funct3[2:1])
                    2'b00:   w_ctrl.alu_ctrl = AluSub;
                    2'b10:   w_ctrl.alu_ctrl = AluSlt;
                    2'b11:   w_ctrl.alu_ctrl = AluSltu;
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                w_ctrl.jump       = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.result_src = ResPc4;
            end
            OP_JALR: begin
                w_ctrl.jump       = 1'b1;
                w_ctrl.jump_reg   = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.result_src = ResPc4;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_ctrl   = AluAdd;
            end
            OP_LUI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_ctrl  = AluPassB;
            end
            OP_AUIPC: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.src_a_pc  = 1'b1;
                w_ctrl.alu_ctrl  = AluAdd;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // An illegal encoding carries only the flag so nothing downstream acts on it.
    always_comb begin
        o_ctrl = w_ctrl;
        if (w_illegal) begin
            o_ctrl         = '0;
            o_ctrl.illegal = 1'b1;
        end
    end

    assign o_dec_muldiv = w_ctrl.is_muldiv && !w_illegal;

endmodule

// File: rtl/ctrl_decode_stage.sv
// Decode stage: single-entry registered control bundle with valid/ready on both sides
// and issue throttling for the non-pipelined mul/div unit.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter bit          ENABLE_M   = 1'b1,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic        reg_write_o,
    output logic [1:0]  result_src_o,
    output logic        mem_write_o,
    output logic        jump_o,
    output logic        branch_o,
    output logic [3:0]  alu_ctrl_o,
    output logic        alu_src_o,
    output logic        src_a_pc_o,
    output logic        jump_reg_o,
    output logic        is_word_op_o,
    output logic        is_muldiv_o,
    output logic        illegal_o
);

    localparam logic [3:0] MdLoad = 4'(MULDIV_LAT);

    if (MULDIV_LAT < 1 || MULDIV_LAT > 15) begin : g_bad_lat
        $error("MULDIV_LAT must be in 1..15");
    end

    ctrl_bundle_t w_dec;
    logic         w_dec_muldiv;
    logic         w_accept;
    logic         r_valid;
    logic [31:0]  r_instr;
    ctrl_bundle_t r_ctrl;
    logic [3:0]   r_md_cnt;

    ctrl_decode_comb #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .i_instr      (instr_i),
        .o_ctrl       (w_dec),
        .o_dec_muldiv (w_dec_muldiv)
    );

    // Only a mul/div waits on the busy counter; everything else issues freely.
    assign in_ready_o = !flush_i && (!r_valid || out_ready_i)
                        && !(w_dec_muldiv && (r_md_cnt != 4'd0));
    assign w_accept   = in_valid_i && in_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_ctrl  <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_instr <= instr_i;
            r_ctrl  <= w_dec;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= 4'd0;
        end else if (w_accept && w_dec_muldiv) begin
            r_md_cnt <= MdLoad;
        end else if (r_md_cnt != 4'd0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    assign out_valid_o  = r_valid;
    assign instr_o      = r_instr;
    assign reg_write_o  = r_ctrl.reg_write;
    assign result_src_o = r_ctrl.result_src;
    assign mem_write_o  = r_ctrl.mem_write;
    assign jump_o       = r_ctrl.jump;
    assign branch_o     = r_ctrl.branch;
    assign alu_ctrl_o   = r_ctrl.alu_ctrl;
    assign alu_src_o    = r_ctrl.alu_src;
    assign src_a_pc_o   = r_ctrl.src_a_pc;
    assign jump_reg_o   = r_ctrl.jump_reg;
    assign is_word_op_o = r_ctrl.is_word_op;
    assign is_muldiv_o  = r_ctrl.is_muldiv;
    assign illegal_o    = r_ctrl.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: directed handshake/throttle/flush/reset steps, then random
// decode against a reference model on RV32+M, RV64+M and RV32-without-M instances.
module tb_ctrl_decode_stage;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_ADDW = 32'h0020803B;
    localparam logic [31:0] I_JALR = 32'h000080E7;

    logic        clk = 1'b0;
    logic        rst_n, flush_i, in_valid_i, out_ready_i;
    logic [31:0] instr_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance a: XLEN=32, M on.  b: XLEN=64, M on.  c: XLEN=32, M off.
    logic a_in_ready, a_out_valid, a_rw, a_mw, a_j, a_br, a_asrc, a_apc, a_jr, a_w, a_md, a_ill;
    logic b_in_ready, b_out_valid, b_rw, b_mw, b_j, b_br, b_asrc, b_apc, b_jr, b_w, b_md, b_ill;
    logic c_in_ready, c_out_valid, c_rw, c_mw, c_j, c_br, c_asrc, c_apc, c_jr, c_w, c_md, c_ill;
    logic [31:0] a_instr, b_instr, c_instr;
    logic [1:0]  a_rs, b_rs, c_rs;
    logic [3:0]  a_alu, b_alu, c_alu;
    logic [15:0] a_bun, b_bun, c_bun;

    assign a_bun = {a_rw, a_rs, a_mw, a_j, a_br, a_alu, a_asrc, a_apc, a_jr, a_w, a_md, a_ill};
    assign b_bun = {b_rw, b_rs, b_mw, b_j, b_br, b_alu, b_asrc, b_apc, b_jr, b_w, b_md, b_ill};
    assign c_bun = {c_rw, c_rs, c_mw, c_j, c_br, c_alu, c_asrc, c_apc, c_jr, c_w, c_md, c_ill};

    ctrl_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .MULDIV_LAT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(a_in_ready), .instr_i(instr_i), .out_valid_o(a_out_valid),
        .out_ready_i(out_ready_i), .instr_o(a_instr), .reg_write_o(a_rw),
        .result_src_o(a_rs), .mem_write_o(a_mw), .jump_o(a_j), .branch_o(a_br),
        .alu_ctrl_o(a_alu), .alu_src_o(a_asrc), .src_a_pc_o(a_apc), .jump_reg_o(a_jr),
        .is_word_op_o(a_w), .is_muldiv_o(a_md), .illegal_o(a_ill)
    );

    ctrl_decode_stage #(.XLEN(64), .ENABLE_M(1'b1), .MULDIV_LAT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(b_in_ready), .instr_i(instr_i), .out_valid_o(b_out_valid),
        .out_ready_i(out_ready_i), .instr_o(b_instr), .reg_write_o(b_rw),
        .result_src_o(b_rs), .mem_write_o(b_mw), .jump_o(b_j), .branch_o(b_br),
        .alu_ctrl_o(b_alu), .alu_src_o(b_asrc), .src_a_pc_o(b_apc), .jump_reg_o(b_jr),
        .is_word_op_o(b_w), .is_muldiv_o(b_md), .illegal_o(b_ill)
    );

    ctrl_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .MULDIV_LAT(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(c_in_ready), .instr_i(instr_i), .out_valid_o(c_out_valid),
        .out_ready_i(out_ready_i), .instr_o(c_instr), .reg_write_o(c_rw),
        .result_src_o(c_rs), .mem_write_o(c_mw), .jump_o(c_j), .branch_o(c_br),
        .alu_ctrl_o(c_alu), .alu_src_o(c_asrc), .src_a_pc_o(c_apc), .jump_reg_o(c_jr),
        .is_word_op_o(c_w), .is_muldiv_o(c_md), .illegal_o(c_ill)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bundle, same bit order as a_bun.  Illegal encodings yield only bit 0.
    function automatic logic [15:0] ref_decode(input logic [31:0] ins, input int xlen,
                                               input bit en_m);
        int  f3_alu [8];
        int  alu  = 0;
        int  rs   = 0;
        bit  rw = 0, mw = 0, j = 0, b = 0, asrc = 0, apc = 0, jr = 0, w = 0, md = 0, ill = 0;
        logic [6:0] op = ins[6:0];
        int  f3 = int'(ins[14:12]);
        logic [6:0] f7 = ins[31:25];
        f3_alu = '{0, 7, 5, 6, 4, 8, 3, 2};
        if (op == 7'h1B || op == 7'h3B) begin
            w   = 1;
            ill = (xlen != 64);
            op  = (op == 7'h1B) ? 7'h13 : 7'h33;
        end
        if (op == 7'h03) begin
            rw = 1; rs = 1; asrc = 1;
        end else if (op == 7'h23) begin
            mw = 1; asrc = 1;
        end else if (op == 7'h33 && f7 == 7'd1) begin
            ill = ill || !en_m; rw = 1; rs = 3; md = 1;
        end else if (op == 7'h33) begin
            rw  = 1;
            alu = f3_alu[f3];
            if (f7[5] && f3 == 0) alu = 1;
            if (f7[5] && f3 == 5) alu = 9;
        end else if (op == 7'h13) begin
            rw = 1; asrc = 1;
            alu = f3_alu[f3];
            if (f7[5] && f3 == 5) alu = 9;
        end else if (op == 7'h63) begin
            b   = 1;
            alu = (f3 < 2) ? 1 : (f3 < 4) ? 0 : (f3 < 6) ? 5 : 6;
            ill = (f3 == 2 || f3 == 3);
        end else if (op == 7'h6F) begin
            j = 1; rw = 1; rs = 2;
        end else if (op == 7'h67) begin
            j = 1; jr = 1; rw = 1; rs = 2; asrc = 1;
        end else if (op == 7'h37) begin
            rw = 1; asrc = 1; alu = 10;
        end else if (op == 7'h17) begin
            rw = 1; asrc = 1; apc = 1;
        end else begin
            ill = 1;
        end
        if (ill) return 16'h0001;
        return {rw, rs[1:0], mw, j, b, alu[3:0], asrc, apc, jr, w, md, 1'b0};
    endfunction

    // Illegal bundles are only pinned on illegal, reg_write, mem_write, jump and branch.
    function automatic logic [15:0] mask_for(input logic [15:0] exp);
        return exp[0] ? 16'h9C01 : 16'hFFFF;
    endfunction

    initial begin
        logic [31:0] ins;
        logic [31:0] rnd;
        logic [15:0] exp_b;
        logic [6:0]  ops [12];
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h1B, 7'h3B,
                7'h0F};

        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; instr_i = '0;
        repeat (2) tick();
        check("reset_a", {a_out_valid, a_instr, a_bun}, '0);
        check("reset_b", {b_out_valid, b_instr, b_bun}, '0);
        rst_n = 1'b1;
        tick();

        // Single ADD, one-cycle latency
        instr_i = I_ADD; in_valid_i = 1'b1; out_ready_i = 1'b1;
        #1 check("add_ready", a_in_ready, 1'b1);
        tick();
        in_valid_i = 1'b0;
        check("add_valid", a_out_valid, 1'b1);
        check("add_instr", a_instr, I_ADD);
        check("add_bundle", a_bun, {1'b1, 2'b00, 3'b000, 4'd0, 6'b0});
        tick();
        check("add_drained", a_out_valid, 1'b0);

        // Back-pressure: LW held, BEQ waits, then accepted on the consume cycle
        instr_i = I_LW; in_valid_i = 1'b1; out_ready_i = 1'b0;
        tick();
        check("lw_instr", a_instr, I_LW);
        check("lw_bundle", a_bun, ref_decode(I_LW, 32, 1'b1));
        instr_i = I_BEQ;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", a_in_ready, 1'b0);
            tick();
            check("bp_frozen", {a_out_valid, a_instr, a_rs}, {1'b1, I_LW, 2'b01});
        end
        out_ready_i = 1'b1;
        #1 check("bp_release_ready", a_in_ready, 1'b1);
        tick();
        check("beq_loaded", {a_out_valid, a_instr}, {1'b1, I_BEQ});
        check("beq_bundle", a_bun, {10'b000_0_0_1_0001, 6'b0});
        in_valid_i = 1'b0;
        tick();
        check("beq_drained", a_out_valid, 1'b0);

        // Mul/div spacing with an ADD slipping in at cycle 1
        instr_i = I_MUL; in_valid_i = 1'b1; out_ready_i = 1'b1;
        #1 check("mul0_ready", a_in_ready, 1'b1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            instr_i = (k == 1) ? I_ADD : I_MUL;
            if (k == 1) check("mul0_bundle", a_bun, ref_decode(I_MUL, 32, 1'b1));
            if (k == 2) check("add_between", a_instr, I_ADD);
            #1 check($sformatf("md_ready_c%0d", k), a_in_ready, (k == 1 || k == 5));
            tick();
        end
        check("mul1_loaded", {a_out_valid, a_instr}, {1'b1, I_MUL});
        in_valid_i = 1'b0;
        repeat (6) tick();

        // Parameter-dependent legality
        instr_i = I_ADDW; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("addw_rv32", {a_ill, a_rw}, 2'b10);
        check("addw_rv64", {b_ill, b_rw, b_w}, 3'b011);
        check("addw_rv64_bundle", b_bun, ref_decode(I_ADDW, 64, 1'b1));
        tick();
        instr_i = I_MUL; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("mul_no_m", {c_ill, c_rw, c_md}, 3'b100);
        check("mul_with_m", {a_ill, a_md}, 2'b01);
        repeat (6) tick();

        // Flush drops the incoming ADD; busy counter keeps running
        instr_i = I_MUL; in_valid_i = 1'b1;
        tick();
        instr_i = I_ADD; flush_i = 1'b1;
        #1 check("flush_ready", a_in_ready, 1'b0);
        tick();
        flush_i = 1'b0;
        check("flush_valid", a_out_valid, 1'b0);
        instr_i = I_MUL;
        for (int k = 2; k <= 5; k++) begin
            if (k == 2) check("flush_dropped", a_out_valid, 1'b0);
            #1 check($sformatf("flush_md_c%0d", k), a_in_ready, (k == 5));
            tick();
        end
        check("flush_mul_loaded", {a_out_valid, a_instr}, {1'b1, I_MUL});
        in_valid_i = 1'b0;
        repeat (6) tick();

        // Asynchronous reset while holding JALR, with the busy counter nonzero
        instr_i = I_MUL; in_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        instr_i = I_JALR;
        tick();
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        check("jalr_held", {a_out_valid, a_instr}, {1'b1, I_JALR});
        check("jalr_bundle", a_bun, {1'b1, 2'b10, 3'b010, 4'd0, 6'b101000});
        #2 rst_n = 1'b0;
        #1 check("async_reset", {a_out_valid, a_instr, a_bun}, '0);
        #1 rst_n = 1'b1;
        instr_i = I_MUL; in_valid_i = 1'b1; out_ready_i = 1'b1;
        #1 check("md_cleared", a_in_ready, 1'b1);
        tick();
        check("post_reset_mul", {a_out_valid, a_instr}, {1'b1, I_MUL});
        in_valid_i = 1'b0;
        repeat (6) tick();

        // Random decode on all three configurations
        for (int n = 0; n < 150; n++) begin
            rnd = $urandom;
            ins = {rnd[31:7], ops[$urandom_range(0, 11)]};
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'b0000001;
                1: ins[31:25] = 7'b0100000;
                2: ins[31:25] = 7'b0000000;
                default: ;
            endcase
            instr_i = ins; in_valid_i = 1'b1;
            tick();
            in_valid_i = 1'b0;
            check("rnd_a_valid", {a_out_valid, a_instr}, {1'b1, ins});
            exp_b = ref_decode(ins, 32, 1'b1);
            check($sformatf("rnd_a %08h", ins), a_bun & mask_for(exp_b), exp_b & mask_for(exp_b));
            exp_b = ref_decode(ins, 64, 1'b1);
            check($sformatf("rnd_b %08h", ins), b_bun & mask_for(exp_b), exp_b & mask_for(exp_b));
            exp_b = ref_decode(ins, 32, 1'b0);
            check($sformatf("rnd_c %08h", ins), c_bun & mask_for(exp_b), exp_b & mask_for(exp_b));
            repeat (5) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered, parametrised decode-stage controller for the RV32/RV64 integer core.
- Decodes one 32-bit instruction into the execute control bundle and holds it in a single-entry output register with valid/ready handshakes on both sides.
- Adds XLEN-dependent word-op legality, optional M-extension decode, illegal-instruction flagging, flush, and issue throttling for the non-pipelined mul/div unit.
- Sits between the fetch/decode pipeline register and the execute stage.

Parameters:
- XLEN, 32, datapath width (32 or 64); word ops are legal only when 64.
- ENABLE_M, 1, decode MUL/DIV/REM when 1; otherwise those encodings are illegal.
- MULDIV_LAT, 4, busy cycles of the mul/div unit after each issue; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  kill the held and incoming instruction
- in_valid_i  in  1  instr_i valid
- in_ready_o  out  1  stage accepts instr_i this cycle
- instr_i  in  32  instruction word
- out_valid_o  out  1  control bundle valid
- out_ready_i  in  1  execute consumes the bundle
- instr_o  out  32  registered instruction, for rd/rs/imm extraction
- reg_write_o  out  1  register-file write
- result_src_o  out  2  00 ALU, 01 memory, 10 PC+4, 11 mul/div
- mem_write_o  out  1  store
- jump_o  out  1  JAL/JALR
- branch_o  out  1  conditional branch
- alu_ctrl_o  out  4  ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10
- alu_src_o  out  1  B operand is the immediate
- src_a_pc_o  out  1  A operand is the PC
- jump_reg_o  out  1  JALR target
- is_word_op_o  out  1  RV64 *W operation
- is_muldiv_o  out  1  M-extension operation; funct3 in instr_o selects the op
- illegal_o  out  1  unsupported or disallowed encoding

Behaviour:
- Reset (async, rst_n=0):
  - out_valid_o=0, instr_o=0, every control output 0, busy counter md_cnt=0.
  - Reset mid-transfer drops the held bundle.
- Latency: one cycle. Data accepted at edge t is visible with out_valid_o=1 after t.
- Handshake:
  - accept = in_valid_i && in_ready_o.
  - in_ready_o = !flush_i && (!out_valid_o || out_ready_i) && !(dec_muldiv && md_cnt!=0). dec_muldiv is the combinational decode of instr_i.
  - Payload changes only on accept and stays stable while out_valid_o && !out_ready_i.
  - Consumption without a new accept clears out_valid_o. Simultaneous consume and accept reloads, so full throughput is sustained.
- Flush: the next out_valid_o is 0 and nothing is accepted that cycle. Flush has priority over accept and consume. md_cnt is unaffected.
- Busy counter:
  - On acceptance of a mul/div op, md_cnt is loaded with MULDIV_LAT.
  - Otherwise md_cnt decrements while nonzero.
  - Minimum spacing between two mul/div accepts is MULDIV_LAT+1 cycles.
  - Non-mul/div instructions are never blocked by md_cnt.
- Decode by opcode (fields not listed are 0):
  - 0000011 load: reg_write, result_src=01, alu_src, ADD.
  - 0100011 store: mem_write, alu_src, ADD.
  - 0110011 R-type: reg_write; ALU op from funct3. funct7[5] selects SUB over ADD and SRA over SRL.
  - 0110011 with funct7=0000001: is_muldiv, result_src=11. Illegal if ENABLE_M=0.
  - 0010011 I-ALU: reg_write, alu_src. funct7[5] is honoured only for shifts; funct3=000 is always ADD.
  - 1100011 branch: branch. BEQ/BNE use SUB, BLT/BGE use SLT, BLTU/BGEU use SLTU. funct3 010/011 are illegal.
  - 1101111 JAL: jump, reg_write, result_src=10.
  - 1100111 JALR: jump, jump_reg, reg_write, result_src=10, alu_src, ADD.
  - 0110111 LUI: reg_write, alu_src, PASSB.
  - 0010111 AUIPC: reg_write, alu_src, src_a_pc, ADD.
  - 0011011 and 0111011 (XLEN=64 only): as I-ALU and R-type respectively, plus is_word_op. Illegal when XLEN=32. Word mul/div follows the ENABLE_M rule.
  - Any other opcode: illegal.
- Illegal instructions still flow through the handshake with illegal_o=1. reg_write, mem_write, jump and branch are forced to 0.

Decomposition:
- ctrl_pkg holds:
  - opcode localparams
  - alu_ctrl_e and result_src_e enums with the values above
  - ctrl_bundle_t packed struct of all control outputs
- Sub-module ctrl_decode_comb: purely combinational instr to ctrl_bundle_t plus dec_muldiv, parametrised by XLEN and ENABLE_M.
- ctrl_decode_stage owns the output register, handshake and md_cnt.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with out_ready_i=1 -> next cycle out_valid_o=1, reg_write_o=1, alu_ctrl_o=0, result_src_o=00, illegal_o=0.
- Back-pressure: accept LW (0x0000A103), hold out_ready_i=0 for 3 cycles while BEQ (0x00208063) is offered -> in_ready_o=0, payload frozen. Release -> BEQ is accepted on the consume cycle with no bubble.
- MULDIV_LAT=4: MUL (0x022081B3) accepted at cycle 0, second MUL offered continuously -> in_ready_o=0 for cycles 1-4, second MUL accepted at cycle 5. An ADD offered at cycle 1 is accepted.
- XLEN=32: ADDW (0x0020803B) -> illegal_o=1, reg_write_o=0. XLEN=64: same word -> is_word_op_o=1, reg_write_o=1. ENABLE_M=0: MUL -> illegal_o=1.
- Flush with out_valid_o=1 and in_valid_i=1 -> next cycle out_valid_o=0, instruction dropped; md_cnt keeps counting.
- rst_n asserted asynchronously mid-cycle while holding a JALR bundle -> out_valid_o and all controls 0 immediately, md_cnt=0.
